mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter sharing one memory port.
// Fair round-robin on ties, with an abort after TIMEOUT unacknowledged BUSY cycles.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a requester raises req with addr/we/wdata stable and holds them
    // until its one-cycle ack; err and rdata are valid while that ack is high.
    // mem_ack is honoured only while mem_req is high.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_last_d;
    logic                r_gnt_d;
    logic [7:0]          r_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_i_ack;
    logic                r_d_ack;
    logic                r_i_err;
    logic                r_d_err;
    logic                w_grant;
    logic                w_pick_d;
    logic                w_hit;
    logic                w_expire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_grant) w_next = ST_BUSY;
            ST_BUSY: if (w_hit || w_expire) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // On a tie, D wins unless D was the previous grantee.
    always_comb begin
        w_grant  = 1'b0;
        w_pick_d = 1'b0;
        w_hit    = 1'b0;
        w_expire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grant  = i_req | d_req;
                w_pick_d = d_req & (~i_req | ~r_last_d);
            end
            ST_BUSY: begin
                w_hit    = mem_ack;
                w_expire = ~mem_ack & (r_cnt == LP_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d    <= 1'b0;
            r_gnt_d     <= 1'b0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_err     <= 1'b0;
            r_d_err     <= 1'b0;
        end else begin
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            r_i_err <= 1'b0;
            r_d_err <= 1'b0;
            if (w_grant) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_pick_d & d_we;
                r_mem_addr  <= w_pick_d ? d_addr : i_addr;
                r_mem_wdata <= w_pick_d ? d_wdata : '0;
                r_gnt_d     <= w_pick_d;
                r_last_d    <= w_pick_d;
                r_cnt       <= '0;
            end else if (w_hit || w_expire) begin
                r_mem_req   <= 1'b0;
                r_mem_we    <= 1'b0;
                r_mem_addr  <= '0;
                r_mem_wdata <= '0;
                if (r_gnt_d) begin
                    r_d_ack <= 1'b1;
                    r_d_err <= w_expire;
                    // A completed store leaves the last load value in place.
                    if (w_expire) r_d_rdata <= '0;
                    else if (!r_mem_we) r_d_rdata <= mem_rdata;
                end else begin
                    r_i_ack   <= 1'b1;
                    r_i_err   <= w_expire;
                    r_i_rdata <= w_expire ? '0 : mem_rdata;
                end
            end else if (r_state == ST_BUSY) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    assign i_rdata     = r_i_rdata;
    assign i_ack       = r_i_ack;
    assign i_err       = r_i_err;
    assign d_rdata     = r_d_rdata;
    assign d_ack       = r_d_ack;
    assign d_err       = r_d_err;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign o_dbg_state = r_state;

endmodule
